ysyx_23060208_xbar_rd: RTL and testbench

// - AXI-Lite read-channel crossbar, 1 master (LSU) to 2 slaves: data SRAM and CLINT; sits directly upstream of the CLINT.
// - Decodes each AR address, forwards it to the selected slave, returns that slave's R beat to the master.
// - Unmapped addresses get an internal DECERR response. One outstanding read at a time.

---
 rtl/ysyx_23060208_pkg.sv | 28 ++
 rtl/ysyx_23060208_addr_dec.sv | 39 +++
 rtl/ysyx_23060208_xbar_rd.sv | 134 +++++++++++++
 tb/tb_ysyx_23060208_xbar_rd.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060208_pkg.sv
// Shared definitions for the ysyx_23060208 AXI-Lite crossbars: address map,
// response codes, crossbar FSM states and slave-select encoding.
package ysyx_23060208_pkg;

  localparam logic [31:0] SRAM_BASE_DEF  = 32'h8000_0000;
  localparam logic [31:0] SRAM_SIZE_DEF  = 32'h0800_0000;
  localparam logic [31:0] CLINT_BASE_DEF = 32'ha000_0048;
  localparam logic [31:0] CLINT_SIZE_DEF = 32'h0000_0008;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR_FWD,
    ST_R_FWD,
    ST_ERR_RESP
  } xbar_state_e;

  // SEL_NONE only appears between reset and the first accepted request.
  typedef enum logic [1:0] {
    SEL_SRAM,
    SEL_CLINT,
    SEL_ERR,
    SEL_NONE
  } slv_sel_e;

endpackage

// File: rtl/ysyx_23060208_addr_dec.sv
// Address decoder shared by the read and write crossbars: maps an address
// onto the SRAM window, the CLINT window, or the error target.
module ysyx_23060208_addr_dec
  import ysyx_23060208_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SRAM_BASE  = SRAM_BASE_DEF,
  parameter logic [DATA_WIDTH-1:0] SRAM_SIZE  = SRAM_SIZE_DEF,
  parameter logic [DATA_WIDTH-1:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [DATA_WIDTH-1:0] CLINT_SIZE = CLINT_SIZE_DEF
) (
  input  logic [DATA_WIDTH-1:0] addr_i,
  output logic [1:0]            sel_o
);

  // One extra bit keeps base+size from wrapping at the top of the map.
  localparam logic [DATA_WIDTH:0] SRAM_LO  = {1'b0, SRAM_BASE};
  localparam logic [DATA_WIDTH:0] SRAM_HI  = {1'b0, SRAM_BASE} + {1'b0, SRAM_SIZE};
  localparam logic [DATA_WIDTH:0] CLINT_LO = {1'b0, CLINT_BASE};
  localparam logic [DATA_WIDTH:0] CLINT_HI = {1'b0, CLINT_BASE} + {1'b0, CLINT_SIZE};

  logic [DATA_WIDTH:0] addr_ext;
  logic                hit_sram;
  logic                hit_clint;

  assign addr_ext  = {1'b0, addr_i};
  assign hit_sram  = (addr_ext >= SRAM_LO) && (addr_ext < SRAM_HI);
  assign hit_clint = (addr_ext >= CLINT_LO) && (addr_ext < CLINT_HI);

  always_comb begin
    sel_o = SEL_ERR;
    if (hit_sram) begin
      sel_o = SEL_SRAM;
    end else if (hit_clint) begin
      sel_o = SEL_CLINT;
    end
  end

endmodule

// File: rtl/ysyx_23060208_xbar_rd.sv
// AXI-Lite read crossbar: one master (LSU) to SRAM and CLINT, one read in
// flight, unmapped addresses answered locally with DECERR.
module ysyx_23060208_xbar_rd
  import ysyx_23060208_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SRAM_BASE  = SRAM_BASE_DEF,
  parameter logic [DATA_WIDTH-1:0] SRAM_SIZE  = SRAM_SIZE_DEF,
  parameter logic [DATA_WIDTH-1:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [DATA_WIDTH-1:0] CLINT_SIZE = CLINT_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] m_araddr,
  input  logic                  m_arvalid,
  output logic                  m_arready,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic [1:0]            m_rresp,
  output logic                  m_rvalid,
  input  logic                  m_rready,
  output logic [DATA_WIDTH-1:0] sram_araddr,
  output logic                  sram_arvalid,
  input  logic                  sram_arready,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic [1:0]            sram_rresp,
  input  logic                  sram_rvalid,
  output logic                  sram_rready,
  output logic [DATA_WIDTH-1:0] clint_araddr,
  output logic                  clint_arvalid,
  input  logic                  clint_arready,
  input  logic [DATA_WIDTH-1:0] clint_rdata,
  input  logic [1:0]            clint_rresp,
  input  logic                  clint_rvalid,
  output logic                  clint_rready
);

  xbar_state_e           state_q, state_d;
  slv_sel_e              sel_q, sel_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            dec_sel;
  logic                  is_sram;
  logic                  is_clint;
  logic                  sel_arready;
  logic                  sel_rvalid;

  ysyx_23060208_addr_dec #(
    .DATA_WIDTH (DATA_WIDTH),
    .SRAM_BASE  (SRAM_BASE),
    .SRAM_SIZE  (SRAM_SIZE),
    .CLINT_BASE (CLINT_BASE),
    .CLINT_SIZE (CLINT_SIZE)
  ) u_addr_dec (
    .addr_i (m_araddr),
    .sel_o  (dec_sel)
  );

  assign is_sram     = (sel_q == SEL_SRAM);
  assign is_clint    = (sel_q == SEL_CLINT);
  assign sel_arready = (is_sram && sram_arready) || (is_clint && clint_arready);
  assign sel_rvalid  = (is_sram && sram_rvalid) || (is_clint && clint_rvalid);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m_arvalid) begin
          addr_d  = m_araddr;
          sel_d   = slv_sel_e'(dec_sel);
          state_d = (dec_sel == SEL_ERR) ? ST_ERR_RESP : ST_AR_FWD;
        end
      end
      ST_AR_FWD: begin
        if (sel_arready) begin
          state_d = ST_R_FWD;
        end
      end
      ST_R_FWD: begin
        if (sel_rvalid && m_rready) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR_RESP: begin
        if (m_rready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_NONE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
    end
  end

  // Slave address buses carry addr_q permanently; arvalid alone qualifies them.
  assign sram_araddr   = addr_q;
  assign clint_araddr  = addr_q;
  assign m_arready     = !rst && (state_q == ST_IDLE);
  assign sram_arvalid  = (state_q == ST_AR_FWD) && is_sram;
  assign clint_arvalid = (state_q == ST_AR_FWD) && is_clint;
  assign sram_rready   = (state_q == ST_R_FWD) && is_sram && m_rready;
  assign clint_rready  = (state_q == ST_R_FWD) && is_clint && m_rready;

  always_comb begin
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_rresp  = RESP_OKAY;
    if (state_q == ST_R_FWD) begin
      if (is_sram) begin
        m_rvalid = sram_rvalid;
        m_rdata  = sram_rdata;
        m_rresp  = sram_rresp;
      end else if (is_clint) begin
        m_rvalid = clint_rvalid;
        m_rdata  = clint_rdata;
        m_rresp  = clint_rresp;
      end
    end else if (state_q == ST_ERR_RESP) begin
      m_rvalid = 1'b1;
      m_rresp  = RESP_DECERR;
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_xbar_rd.sv
// Self-checking bench for the read crossbar: directed corner sequences,
// a decode vector table and randomized reads against a behavioural model.
module tb_ysyx_23060208_xbar_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] sram_araddr;
  logic        sram_arvalid;
  logic        sram_arready;
  logic [31:0] sram_rdata;
  logic [1:0]  sram_rresp;
  logic        sram_rvalid;
  logic        sram_rready;
  logic [31:0] clint_araddr;
  logic        clint_arvalid;
  logic        clint_arready;
  logic [31:0] clint_rdata;
  logic [1:0]  clint_rresp;
  logic        clint_rvalid;
  logic        clint_rready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ysyx_23060208_xbar_rd dut (
    .clk           (clk),
    .rst           (rst),
    .m_araddr      (m_araddr),
    .m_arvalid     (m_arvalid),
    .m_arready     (m_arready),
    .m_rdata       (m_rdata),
    .m_rresp       (m_rresp),
    .m_rvalid      (m_rvalid),
    .m_rready      (m_rready),
    .sram_araddr   (sram_araddr),
    .sram_arvalid  (sram_arvalid),
    .sram_arready  (sram_arready),
    .sram_rdata    (sram_rdata),
    .sram_rresp    (sram_rresp),
    .sram_rvalid   (sram_rvalid),
    .sram_rready   (sram_rready),
    .clint_araddr  (clint_araddr),
    .clint_arvalid (clint_arvalid),
    .clint_arready (clint_arready),
    .clint_rdata   (clint_rdata),
    .clint_rresp   (clint_rresp),
    .clint_rvalid  (clint_rvalid),
    .clint_rready  (clint_rready)
  );

  localparam int T_SRAM  = 0;
  localparam int T_CLINT = 1;
  localparam int T_ERR   = 2;

  typedef struct {
    logic [31:0] addr;
    int          exp_target;
  } dec_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Address map written straight from the window definitions.
  function automatic int model_target(input logic [31:0] a);
    longint unsigned x;
    x = longint'(a);
    if (x >= 64'h8000_0000 && x < 64'h8000_0000 + 64'h0800_0000) return T_SRAM;
    if (x >= 64'ha000_0048 && x < 64'ha000_0048 + 64'h8) return T_CLINT;
    return T_ERR;
  endfunction

  task automatic idle_inputs();
    m_arvalid     = 1'b0;
    m_rready      = 1'b0;
    sram_arready  = 1'b0;
    sram_rvalid   = 1'b0;
    sram_rdata    = '0;
    sram_rresp    = '0;
    clint_arready = 1'b0;
    clint_rvalid  = 1'b0;
    clint_rdata   = '0;
    clint_rresp   = '0;
  endtask

  // One complete read; the bench plays both master and the addressed slave.
  // The other slave (and any slave outside the R phase) keeps rvalid high
  // with junk data, which must never reach the master.
  task automatic do_read(input logic [31:0] addr, input int tgt, input int ar_dly,
                         input int r_dly, input int mr_dly, input logic [31:0] data,
                         input logic [1:0] resp, input string tag);
    bit is_s;
    int hs;
    bit rv;
    is_s = (tgt == T_SRAM);
    m_araddr  = addr;
    m_arvalid = 1'b1;
    #1;
    chk({tag, ".ar_accept"}, m_arready, 1);
    tick();
    m_arvalid = 1'b0;
    m_araddr  = $urandom;
    if (tgt == T_ERR) begin
      for (int i = 0; i <= mr_dly; i++) begin
        m_rready    = (i == mr_dly);
        sram_rvalid = 1'b1;  sram_rdata  = 32'hdead_beef;
        clint_rvalid = 1'b1; clint_rdata = 32'hdead_beef;
        #1;
        chk({tag, ".err_rvalid"}, m_rvalid, 1);
        chk({tag, ".err_rresp"}, m_rresp, 2'b11);
        chk({tag, ".err_rdata"}, m_rdata, 0);
        chk({tag, ".err_no_slave_ar"}, {sram_arvalid, clint_arvalid}, 0);
        chk({tag, ".err_busy"}, m_arready, 0);
        tick();
      end
    end else begin
      for (int i = 0; i <= ar_dly; i++) begin
        sram_arready  = is_s && (i == ar_dly);
        clint_arready = !is_s && (i == ar_dly);
        sram_rvalid   = 1'b1; sram_rdata  = 32'hdead_beef;
        clint_rvalid  = 1'b1; clint_rdata = 32'hdead_beef;
        m_rready      = 1'b1;
        #1;
        chk({tag, ".sel_arvalid"}, is_s ? sram_arvalid : clint_arvalid, 1);
        chk({tag, ".oth_arvalid"}, is_s ? clint_arvalid : sram_arvalid, 0);
        chk({tag, ".araddr"}, is_s ? sram_araddr : clint_araddr, addr);
        chk({tag, ".ar_rvalid"}, m_rvalid, 0);
        chk({tag, ".ar_busy"}, m_arready, 0);
        tick();
      end
      sram_arready  = 1'b0;
      clint_arready = 1'b0;
      hs = (r_dly > mr_dly) ? r_dly : mr_dly;
      for (int i = 0; i <= hs; i++) begin
        rv       = (i >= r_dly);
        m_rready = (i >= mr_dly);
        if (is_s) begin
          sram_rvalid  = rv; sram_rdata = rv ? data : $urandom; sram_rresp = rv ? resp : 2'($urandom);
          clint_rvalid = 1'b1; clint_rdata = 32'hdead_beef; clint_rresp = 2'b10;
        end else begin
          clint_rvalid = rv; clint_rdata = rv ? data : $urandom; clint_rresp = rv ? resp : 2'($urandom);
          sram_rvalid  = 1'b1; sram_rdata = 32'hdead_beef; sram_rresp = 2'b10;
        end
        #1;
        chk({tag, ".rvalid"}, m_rvalid, rv);
        if (rv) begin
          chk({tag, ".rdata"}, m_rdata, data);
          chk({tag, ".rresp"}, m_rresp, resp);
        end
        chk({tag, ".sel_rready"}, is_s ? sram_rready : clint_rready, m_rready);
        chk({tag, ".oth_rready"}, is_s ? clint_rready : sram_rready, 0);
        tick();
      end
    end
    idle_inputs();
    #1;
    chk({tag, ".back_idle"}, m_arready, 1);
    chk({tag, ".idle_rvalid"}, m_rvalid, 0);
    chk({tag, ".idle_rdata"}, m_rdata, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_vec_t    vecs[10];
    logic [31:0] a;
    int          kind;

    vecs[0] = '{32'h7fff_fffc, T_ERR};
    vecs[1] = '{32'h8000_0000, T_SRAM};
    vecs[2] = '{32'h87ff_fffc, T_SRAM};
    vecs[3] = '{32'h8800_0000, T_ERR};
    vecs[4] = '{32'ha000_0044, T_ERR};
    vecs[5] = '{32'ha000_0048, T_CLINT};
    vecs[6] = '{32'ha000_004c, T_CLINT};
    vecs[7] = '{32'ha000_0050, T_ERR};
    vecs[8] = '{32'h0000_0000, T_ERR};
    vecs[9] = '{32'hffff_fffc, T_ERR};

    rst       = 1'b1;
    m_araddr  = '0;
    idle_inputs();
    m_arvalid = 1'b1;
    tick();
    tick();
    chk("rst.arready", m_arready, 0);
    chk("rst.arvalids", {sram_arvalid, clint_arvalid}, 0);
    chk("rst.rvalid", m_rvalid, 0);
    chk("rst.rreadys", {sram_rready, clint_rready}, 0);
    chk("rst.araddr", sram_araddr, 0);
    m_arvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst.release_arready", m_arready, 1);
    tick();

    do_read(32'h8000_0000, T_SRAM, 0, 1, 0, 32'h1234_5678, 2'b00, "sram_basic");
    do_read(32'ha000_0048, T_CLINT, 2, 0, 0, 32'h0000_0001, 2'b00, "clint_basic");
    do_read(32'h1000_0000, T_ERR, 0, 0, 3, 32'h0, 2'b00, "unmapped");

    // Second request while a CLINT read is in flight must stall until R completes.
    m_araddr = 32'ha000_0048; m_arvalid = 1'b1;
    #1; chk("busy.first_accept", m_arready, 1);
    tick();
    m_araddr = 32'h8000_0010;
    clint_arready = 1'b1;
    #1; chk("busy.ar_fwd_arready", m_arready, 0);
    chk("busy.clint_arvalid", clint_arvalid, 1);
    tick();
    clint_arready = 1'b0; m_rready = 1'b1;
    #1; chk("busy.r_wait_arready", m_arready, 0);
    tick();
    clint_rvalid = 1'b1; clint_rdata = 32'h0000_0055;
    #1; chk("busy.r_hs_arready", m_arready, 0);
    chk("busy.r_hs_rdata", m_rdata, 32'h0000_0055);
    tick();
    clint_rvalid = 1'b0; m_rready = 1'b0;
    #1; chk("busy.second_accept", m_arready, 1);
    tick();
    m_arvalid = 1'b0;
    #1; chk("busy.second_sram_arvalid", sram_arvalid, 1);
    chk("busy.second_araddr", sram_araddr, 32'h8000_0010);
    sram_arready = 1'b1;
    tick();
    sram_arready = 1'b0; sram_rvalid = 1'b1; sram_rdata = 32'h0bad_cafe; m_rready = 1'b1;
    #1; chk("busy.second_rdata", m_rdata, 32'h0bad_cafe);
    tick();
    idle_inputs();

    // Reset in the middle of AR_FWD aborts the read.
    m_araddr = 32'h8000_0004; m_arvalid = 1'b1;
    tick();
    m_arvalid = 1'b0;
    #1; chk("abort.pre_arvalid", sram_arvalid, 1);
    tick();
    rst = 1'b1; sram_rvalid = 1'b1; sram_rdata = 32'h1111_2222; m_rready = 1'b1;
    #1;
    chk("abort.arvalids", {sram_arvalid, clint_arvalid}, 0);
    chk("abort.rvalid", m_rvalid, 0);
    chk("abort.arready", m_arready, 0);
    tick();
    chk("abort.arready_hold", m_arready, 0);
    rst = 1'b0;
    #1;
    chk("abort.release_arready", m_arready, 1);
    chk("abort.no_response", m_rvalid, 0);
    tick();
    chk("abort.still_idle", {m_rvalid, sram_arvalid}, 0);
    idle_inputs();

    for (int i = 0; i < 10; i++) begin
      do_read(vecs[i].addr, vecs[i].exp_target, i % 3, (i + 1) % 3, i % 2,
              $urandom, 2'(i), $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 0)      a = 32'h8000_0000 + ($urandom % 32'h0800_0000);
      else if (kind == 1) a = 32'ha000_0040 + ($urandom % 32'h18);
      else                a = $urandom;
      do_read(a, model_target(a), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), $urandom, 2'($urandom), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
